// File: rtl/riscv_wb.sv
// Writeback stage: buffers {rd, data} results in a 2-deep FIFO and drains them into the register file.
// Latency: one cycle minimum from accept to the register-file write. Bypass taps the youngest buffered entry.
// Backpressure: ack drops when both entries are full or a flush is in progress. wb_rf_busy stalls the drain.
//
// Ports:
//   clk, rstn                                  clock, asynchronous active-low reset
//   mem_wb_rdy/ack, mem_wb_rd, mem_wb_data     result handshake from the memory stage
//   wb_flush                                   drop every buffered result
//   wb_rf_busy                                 register-file write port unavailable this cycle
//   wb_rf_we/addr/data                         register-file write port
//   wb_fwd_vld/rd/data                         bypass from the youngest buffered result
//   wb_instret                                 64-bit count of retired results
module riscv_wb (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_wb_rdy,
  output logic        mem_wb_ack,
  input  logic [31:0] mem_wb_data,
  input  logic [4:0]  mem_wb_rd,
  input  logic        wb_flush,
  input  logic        wb_rf_busy,
  output logic        wb_rf_we,
  output logic [4:0]  wb_rf_addr,
  output logic [31:0] wb_rf_data,
  output logic        wb_fwd_vld,
  output logic [4:0]  wb_fwd_rd,
  output logic [31:0] wb_fwd_data,
  output logic [63:0] wb_instret
);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t      fifo_q [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;
  logic [63:0] instret_q;

  logic        push;
  logic        retire;
  logic        not_empty;
  logic [1:0]  count_d;
  entry_t      head;
  entry_t      youngest;

  assign not_empty = (count_q != 2'd0);
  assign head      = fifo_q[rd_ptr_q];
  // The youngest entry sits just behind the write pointer.
  assign youngest  = fifo_q[~wr_ptr_q];

  // Ack depends only on registered occupancy and the flush, never on rdy.
  assign mem_wb_ack = (count_q != 2'd2) & ~wb_flush;
  assign push       = mem_wb_rdy & mem_wb_ack;
  assign retire     = not_empty & ~wb_rf_busy & ~wb_flush;

  always_comb begin
    wb_rf_we    = 1'b0;
    wb_rf_addr  = '0;
    wb_rf_data  = '0;
    wb_fwd_vld  = 1'b0;
    wb_fwd_rd   = '0;
    wb_fwd_data = '0;
    if (not_empty) begin
      wb_rf_addr = head.rd;
      wb_rf_data = head.data;
      // x0 entries retire silently: no write strobe.
      wb_rf_we   = retire & (head.rd != 5'd0);
      if (youngest.rd != 5'd0) begin
        wb_fwd_vld  = 1'b1;
        wb_fwd_rd   = youngest.rd;
        wb_fwd_data = youngest.data;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (wb_flush) begin
      count_d = 2'd0;
    end else begin
      // A simultaneous push and retire leaves occupancy unchanged.
      case ({push, retire})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      instret_q <= '0;
    end else begin
      count_q <= count_d;
      if (wb_flush) begin
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        if (push) begin
          fifo_q[wr_ptr_q] <= '{rd: mem_wb_rd, data: mem_wb_data};
          wr_ptr_q         <= ~wr_ptr_q;
        end
        if (retire) begin
          rd_ptr_q  <= ~rd_ptr_q;
          instret_q <= instret_q + 64'd1;
        end
      end
    end
  end

  assign wb_instret = instret_q;

endmodule

// File: tb/tb_riscv_wb.sv
module tb_riscv_wb;

  logic        clk;
  logic        rstn;
  logic        mem_wb_rdy;
  logic        mem_wb_ack;
  logic [31:0] mem_wb_data;
  logic [4:0]  mem_wb_rd;
  logic        wb_flush;
  logic        wb_rf_busy;
  logic        wb_rf_we;
  logic [4:0]  wb_rf_addr;
  logic [31:0] wb_rf_data;
  logic        wb_fwd_vld;
  logic [4:0]  wb_fwd_rd;
  logic [31:0] wb_fwd_data;
  logic [63:0] wb_instret;

  riscv_wb dut (
    .clk         (clk),
    .rstn        (rstn),
    .mem_wb_rdy  (mem_wb_rdy),
    .mem_wb_ack  (mem_wb_ack),
    .mem_wb_data (mem_wb_data),
    .mem_wb_rd   (mem_wb_rd),
    .wb_flush    (wb_flush),
    .wb_rf_busy  (wb_rf_busy),
    .wb_rf_we    (wb_rf_we),
    .wb_rf_addr  (wb_rf_addr),
    .wb_rf_data  (wb_rf_data),
    .wb_fwd_vld  (wb_fwd_vld),
    .wb_fwd_rd   (wb_fwd_rd),
    .wb_fwd_data (wb_fwd_data),
    .wb_instret  (wb_instret)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of pending results plus a retire tally.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic [63:0] n_ret = '0;        // retires seen by the model since reset
  logic [63:0] instret_base = '0; // offset applied when the counter is preloaded

  always @(negedge clk) begin
    int   sz;
    ent_t e;
    logic e_ack, e_we, e_fv;
    logic [4:0]  e_addr, e_frd;
    logic [31:0] e_data, e_fd;
    if (!rstn) begin
      q.delete();
      n_ret = '0;
    end
    sz     = q.size();
    e_ack  = (sz < 2) && !wb_flush;
    e_we   = 1'b0;
    e_addr = '0;
    e_data = '0;
    e_fv   = 1'b0;
    e_frd  = '0;
    e_fd   = '0;
    if (sz > 0) begin
      e_addr = q[0].rd;
      e_data = q[0].data;
      e_we   = !wb_rf_busy && !wb_flush && (q[0].rd != 5'd0);
      if (q[sz-1].rd != 5'd0) begin
        e_fv  = 1'b1;
        e_frd = q[sz-1].rd;
        e_fd  = q[sz-1].data;
      end
    end
    chk("ack",     64'(mem_wb_ack),  64'(e_ack));
    chk("rf_we",   64'(wb_rf_we),    64'(e_we));
    chk("rf_addr", 64'(wb_rf_addr),  64'(e_addr));
    chk("rf_data", 64'(wb_rf_data),  64'(e_data));
    chk("fwd_vld", 64'(wb_fwd_vld),  64'(e_fv));
    chk("fwd_rd",  64'(wb_fwd_rd),   64'(e_frd));
    chk("fwd_dat", 64'(wb_fwd_data), 64'(e_fd));
    chk("instret", wb_instret,       instret_base + n_ret);
    // Inputs are stable until after the coming rising edge: advance the model now.
    if (rstn) begin
      if (wb_flush) begin
        q.delete();
      end else begin
        if (sz > 0 && !wb_rf_busy) begin
          void'(q.pop_front());
          n_ret = n_ret + 64'd1;
        end
        if (mem_wb_rdy && sz < 2) begin
          e.rd   = mem_wb_rd;
          e.data = mem_wb_data;
          q.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn        = 1'b0;
    mem_wb_rdy  = 1'b0;
    mem_wb_data = '0;
    mem_wb_rd   = '0;
    wb_flush    = 1'b0;
    wb_rf_busy  = 1'b0;
    #2;
    chk("rst_ack",     64'(mem_wb_ack), 64'd1);
    chk("rst_rf_we",   64'(wb_rf_we),   64'd0);
    chk("rst_instret", wb_instret,      64'd0);
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // Stream: rd 1..4, data 0x11..0x14, one write per cycle one cycle behind.
    for (int i = 0; i < 4; i++) begin
      mem_wb_rdy  = 1'b1;
      mem_wb_rd   = 5'(i + 1);
      mem_wb_data = 32'h11 + 32'(i);
      #2;
      if (i == 0) begin
        chk("stream_lat_we", 64'(wb_rf_we), 64'd0);
      end else begin
        chk("stream_addr", 64'(wb_rf_addr), 64'(i));
        chk("stream_data", 64'(wb_rf_data), 64'h10 + 64'(i));
      end
      tick();
    end
    mem_wb_rdy = 1'b0;
    #2;
    chk("stream_last_addr", 64'(wb_rf_addr), 64'd4);
    chk("stream_last_we",   64'(wb_rf_we),   64'd1);
    tick();
    #2;
    chk("stream_instret", wb_instret, 64'd4);
    tick();

    // Back-pressure: busy, three results offered, only two fit.
    wb_rf_busy  = 1'b1;
    mem_wb_rdy  = 1'b1;
    mem_wb_rd   = 5'd5;
    mem_wb_data = 32'hA5;
    #2;
    chk("bp_ack0", 64'(mem_wb_ack), 64'd1);
    tick();
    mem_wb_rd   = 5'd6;
    mem_wb_data = 32'hA6;
    tick();
    mem_wb_rd   = 5'd7;
    mem_wb_data = 32'hA7;
    #2;
    chk("bp_ack_full", 64'(mem_wb_ack), 64'd0);
    chk("bp_hold_addr", 64'(wb_rf_addr), 64'd5);
    tick();
    tick();
    wb_rf_busy = 1'b0;
    #2;
    chk("bp_drain0", 64'(wb_rf_addr), 64'd5);
    tick();
    #2;
    chk("bp_drain1", 64'(wb_rf_addr), 64'd6);
    tick();
    mem_wb_rdy = 1'b0;
    #2;
    chk("bp_drain2", 64'(wb_rf_data), 64'hA7);
    tick();
    #2;
    chk("bp_instret", wb_instret, 64'd7);
    tick();

    // x0 destination: retires without a write or a bypass.
    mem_wb_rdy  = 1'b1;
    mem_wb_rd   = 5'd0;
    mem_wb_data = 32'hDEADBEEF;
    tick();
    mem_wb_rdy = 1'b0;
    #2;
    chk("x0_we",   64'(wb_rf_we),   64'd0);
    chk("x0_fwd",  64'(wb_fwd_vld), 64'd0);
    chk("x0_data", 64'(wb_rf_data), 64'hDEADBEEF);
    tick();
    #2;
    chk("x0_instret", wb_instret, 64'd8);
    tick();

    // Flush with two entries held behind a busy register file.
    wb_rf_busy  = 1'b1;
    mem_wb_rdy  = 1'b1;
    mem_wb_rd   = 5'd9;
    mem_wb_data = 32'h99;
    tick();
    mem_wb_rd   = 5'd10;
    mem_wb_data = 32'hAA;
    tick();
    #2;
    chk("fl_fwd_rd", 64'(wb_fwd_rd), 64'd10);
    wb_flush = 1'b1;
    #1;
    chk("fl_ack", 64'(mem_wb_ack), 64'd0);
    chk("fl_we",  64'(wb_rf_we),   64'd0);
    tick();
    wb_flush   = 1'b0;
    mem_wb_rdy = 1'b0;
    wb_rf_busy = 1'b0;
    #2;
    chk("fl_empty_fwd", 64'(wb_fwd_vld), 64'd0);
    chk("fl_empty_ack", 64'(mem_wb_ack), 64'd1);
    tick();
    #2;
    chk("fl_instret", wb_instret, 64'd8);
    tick();

    // Counter wrap: preload all-ones, retire one result.
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    instret_base = 64'hFFFF_FFFF_FFFF_FFFF - n_ret;
    #1;
    release dut.instret_q;
    mem_wb_rdy  = 1'b1;
    mem_wb_rd   = 5'd3;
    mem_wb_data = 32'h33;
    tick();
    mem_wb_rdy = 1'b0;
    tick();
    #2;
    chk("wrap_instret", wb_instret, 64'd0);
    tick();

    // Reset asserted between edges with one entry buffered.
    mem_wb_rdy  = 1'b1;
    mem_wb_rd   = 5'd12;
    mem_wb_data = 32'hCC;
    wb_rf_busy  = 1'b1;
    tick();
    mem_wb_rdy = 1'b0;
    #2;
    rstn = 1'b0;
    instret_base = '0;
    #1;
    chk("rmid_we",   64'(wb_rf_we),    64'd0);
    chk("rmid_addr", 64'(wb_rf_addr),  64'd0);
    chk("rmid_data", 64'(wb_rf_data),  64'd0);
    chk("rmid_fwd",  64'(wb_fwd_vld),  64'd0);
    chk("rmid_frd",  64'(wb_fwd_rd),   64'd0);
    chk("rmid_fdat", 64'(wb_fwd_data), 64'd0);
    chk("rmid_ack",  64'(mem_wb_ack),  64'd1);
    chk("rmid_ret",  wb_instret,       64'd0);
    tick();
    rstn       = 1'b1;
    wb_rf_busy = 1'b0;
    #2;
    chk("rpost_we", 64'(wb_rf_we), 64'd0);
    tick();
    tick();
    #2;
    chk("rpost_instret", wb_instret, 64'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
